// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encodings, digit width
// and default field limits.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_PAUSED = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN    = 2'd1;
    localparam logic [STATE_W-1:0] ST_ADJUST = 2'd2;

    localparam int unsigned MIN_MAX_DEFAULT = 59;
    localparam int unsigned SEC_MAX_DEFAULT = 59;

endpackage

// File: rtl/bcd60_counter.sv
// Two-digit BCD counter 00..MAX with synchronous clear and wrap-around carry.
module bcd60_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = SEC_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clear,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry_out
);

    localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'(MAX / 10);
    localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'(MAX % 10);

    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic               at_max;

    assign at_max    = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign carry_out = inc && at_max;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clear) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == DIGIT_W'(9)) begin
                ones_d = '0;
                tens_d = tens_q + DIGIT_W'(1);
            end else begin
                ones_d = ones_q + DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: run/pause/adjust FSM, time-base edge detection,
// MM:SS BCD time keeping and adjust-mode digit blinking.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_MAX = MIN_MAX_DEFAULT,
    parameter int unsigned SEC_MAX = SEC_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clock1Hz,
    input  logic               clock2Hz,
    input  logic               clockBlink,
    input  logic               pause_btn,
    input  logic               clr_btn,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [3:0]         blank,
    output logic               running
);

    // Prev registers reset to 1 so inputs already high at release give no edge.
    logic c1_prev, c2_prev, pause_prev, clr_prev;
    logic c1_edge, c2_edge, pause_edge, clr_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c1_prev    <= 1'b1;
            c2_prev    <= 1'b1;
            pause_prev <= 1'b1;
            clr_prev   <= 1'b1;
        end else begin
            c1_prev    <= clock1Hz;
            c2_prev    <= clock2Hz;
            pause_prev <= pause_btn;
            clr_prev   <= clr_btn;
        end
    end

    assign c1_edge    = clock1Hz  && !c1_prev;
    assign c2_edge    = clock2Hz  && !c2_prev;
    assign pause_edge = pause_btn && !pause_prev;
    assign clr_edge   = clr_btn   && !clr_prev;

    logic [STATE_W-1:0] state_q, state_d;

    // A clear edge touches only the time; the state waits a cycle.
    always_comb begin
        state_d = state_q;
        if (!clr_edge) begin
            if (adj) begin
                state_d = ST_ADJUST;
            end else if (state_q == ST_ADJUST) begin
                state_d = ST_PAUSED;
            end else if (pause_edge) begin
                state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
            end
        end
    end

    // Ticks are qualified by the state held before this cycle's pause edge.
    logic run_tick, adj_tick;
    logic sec_inc, min_inc;
    logic sec_carry, min_carry_unused;

    assign run_tick = (state_q == ST_RUN) && !adj && c1_edge && !clr_edge;
    assign adj_tick = (state_q == ST_ADJUST) && adj && c2_edge && !clr_edge;
    assign sec_inc  = run_tick || (adj_tick && sel);
    assign min_inc  = (run_tick && sec_carry) || (adj_tick && !sel);

    bcd60_counter #(
        .MAX(SEC_MAX)
    ) u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (sec_inc),
        .clear    (clr_edge),
        .tens     (sec_tens),
        .ones     (sec_ones),
        .carry_out(sec_carry)
    );

    bcd60_counter #(
        .MAX(MIN_MAX)
    ) u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (min_inc),
        .clear    (clr_edge),
        .tens     (min_tens),
        .ones     (min_ones),
        .carry_out(min_carry_unused)
    );

    logic [3:0] blank_d;

    always_comb begin
        blank_d = 4'b0000;
        if ((state_d == ST_ADJUST) && clockBlink) begin
            blank_d = sel ? 4'b0011 : 4'b1100;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PAUSED;
            blank   <= 4'b0000;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            blank   <= blank_d;
            running <= (state_d == ST_RUN);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a vector table plus multi-cycle sequences.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clock1Hz, clock2Hz, clockBlink;
    logic       pause_btn, clr_btn, adj, sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0] blank;
    logic       running;

    int checks   = 0;
    int failures = 0;

    stopwatch_ctrl #(
        .MIN_MAX(59),
        .SEC_MAX(59)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clock1Hz  (clock1Hz),
        .clock2Hz  (clock2Hz),
        .clockBlink(clockBlink),
        .pause_btn (pause_btn),
        .clr_btn   (clr_btn),
        .adj       (adj),
        .sel       (sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .blank     (blank),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic        c;
        logic        a;
        logic        s;
        logic        t1;
        logic        t2;
        logic        tb;
        logic [15:0] tm;
        logic [3:0]  bl;
        logic        run;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    function automatic logic [15:0] time_now();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clock1Hz = 0; clock2Hz = 0; clockBlink = 0;
        pause_btn = 0; clr_btn = 0; adj = 0; sel = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic pulse1();
        clock1Hz = 1; cyc(); clock1Hz = 0; cyc();
    endtask

    task automatic pulse2();
        clock2Hz = 1; cyc(); clock2Hz = 0; cyc();
    endtask

    task automatic pulse_pause();
        pause_btn = 1; cyc(); pause_btn = 0; cyc();
    endtask

    task automatic pulse_clr();
        clr_btn = 1; cyc(); clr_btn = 0; cyc();
    endtask

    initial begin
        //              p  c  a  s  t1 t2 tb  time      blank    run
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'b0000, 1'b0};
        vecs[1]  = '{0, 0, 0, 0, 1, 0, 0, 16'h0000, 4'b0000, 1'b0};
        vecs[2]  = '{1, 0, 0, 0, 0, 0, 0, 16'h0000, 4'b0000, 1'b1};
        vecs[3]  = '{0, 0, 0, 0, 1, 0, 0, 16'h0001, 4'b0000, 1'b1};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0001, 4'b0000, 1'b1};
        vecs[5]  = '{1, 0, 0, 0, 1, 0, 0, 16'h0002, 4'b0000, 1'b0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0002, 4'b0000, 1'b0};
        vecs[7]  = '{1, 0, 0, 0, 1, 0, 0, 16'h0002, 4'b0000, 1'b1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0002, 4'b0000, 1'b1};
        vecs[9]  = '{0, 0, 0, 0, 1, 0, 0, 16'h0003, 4'b0000, 1'b1};
        vecs[10] = '{0, 0, 1, 1, 0, 0, 1, 16'h0003, 4'b0011, 1'b0};
        vecs[11] = '{0, 0, 1, 1, 0, 1, 1, 16'h0004, 4'b0011, 1'b0};
        vecs[12] = '{0, 0, 1, 0, 0, 0, 1, 16'h0004, 4'b1100, 1'b0};
        vecs[13] = '{0, 0, 1, 0, 0, 1, 0, 16'h0104, 4'b0000, 1'b0};
        vecs[14] = '{1, 0, 1, 0, 1, 0, 0, 16'h0104, 4'b0000, 1'b0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 16'h0104, 4'b0000, 1'b0};
        vecs[16] = '{1, 0, 0, 0, 0, 0, 0, 16'h0104, 4'b0000, 1'b1};
        vecs[17] = '{0, 1, 0, 0, 1, 0, 0, 16'h0000, 4'b0000, 1'b1};
        vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'b0000, 1'b1};
        vecs[19] = '{0, 0, 0, 0, 1, 0, 0, 16'h0001, 4'b0000, 1'b1};
        vecs[20] = '{1, 0, 0, 0, 0, 0, 0, 16'h0001, 4'b0000, 1'b0};
        vecs[21] = '{0, 1, 0, 0, 0, 0, 0, 16'h0000, 4'b0000, 1'b0};

        idle_inputs();
        rst = 1'b0;
        #2;
        check("reset_time", time_now(), 16'h0000);
        check("reset_blank", {12'h0, blank}, 16'h0000);
        check("reset_running", {15'h0, running}, 16'h0000);
        cyc();
        rst = 1'b1;
        cyc();

        for (int i = 0; i < NVEC; i++) begin
            pause_btn = vecs[i].p;  clr_btn = vecs[i].c;   adj = vecs[i].a;
            sel = vecs[i].s;        clock1Hz = vecs[i].t1; clock2Hz = vecs[i].t2;
            clockBlink = vecs[i].tb;
            cyc();
            check($sformatf("vec%0d_time", i), time_now(), vecs[i].tm);
            check($sformatf("vec%0d_blank", i), {12'h0, blank}, {12'h0, vecs[i].bl});
            check($sformatf("vec%0d_running", i), {15'h0, running}, {15'h0, vecs[i].run});
        end

        // 60 seconds from 00:00, one step at a time.
        do_reset();
        pulse_pause();
        check("count_running", {15'h0, running}, 16'h0001);
        for (int i = 1; i <= 60; i++) begin
            pulse1();
            check($sformatf("count_step%0d", i), time_now(), to_bcd(i));
        end

        // Preload 59:58 through ADJUST, then wrap 59:59 -> 00:00.
        adj = 1; sel = 0; cyc();
        repeat (58) pulse2();
        sel = 1;
        repeat (58) pulse2();
        check("preload_5958", time_now(), 16'h5958);
        adj = 0; cyc();
        check("adj_exit_paused", {15'h0, running}, 16'h0000);
        pulse_pause();
        pulse1();
        check("wrap_5959", time_now(), 16'h5959);
        pulse1();
        check("wrap_0000", time_now(), 16'h0000);

        // Pause holds the count; resume continues from it.
        repeat (5) pulse1();
        check("run_0005", time_now(), 16'h0005);
        pulse_pause();
        check("paused_running", {15'h0, running}, 16'h0000);
        repeat (3) pulse1();
        check("paused_hold", time_now(), 16'h0005);
        pulse_pause();
        check("resumed_running", {15'h0, running}, 16'h0001);
        pulse1();
        check("resumed_0006", time_now(), 16'h0006);

        // Seconds adjust wraps without carrying into minutes; blink masks.
        pulse_clr();
        check("clr_time", time_now(), 16'h0000);
        check("clr_keeps_run", {15'h0, running}, 16'h0001);
        adj = 1; sel = 1; cyc();
        repeat (62) pulse2();
        check("adj_sec_62", time_now(), 16'h0002);
        clockBlink = 1; cyc();
        check("blink_sec", {12'h0, blank}, 16'h0003);
        sel = 0; cyc();
        check("blink_min", {12'h0, blank}, 16'h000c);
        adj = 0; cyc();
        check("adj_off_blank", {12'h0, blank}, 16'h0000);
        check("adj_off_paused", {15'h0, running}, 16'h0000);
        clockBlink = 0;

        // Clear edge coinciding with a tick at 12:34 in RUN.
        adj = 1; sel = 0; cyc();
        repeat (12) pulse2();
        sel = 1;
        repeat (32) pulse2();
        adj = 0; cyc();
        check("preload_1234", time_now(), 16'h1234);
        pulse_pause();
        clr_btn = 1; clock1Hz = 1; cyc();
        check("clr_tick_time", time_now(), 16'h0000);
        check("clr_tick_run", {15'h0, running}, 16'h0001);
        clr_btn = 0; clock1Hz = 0; cyc();
        pulse1();
        check("after_clr_0001", time_now(), 16'h0001);

        // Asynchronous reset mid-run at 03:21 with inputs high.
        pulse_pause();
        adj = 1; sel = 0; cyc();
        repeat (3) pulse2();
        sel = 1;
        repeat (20) pulse2();
        adj = 0; cyc();
        pulse_pause();
        check("preload_0321", time_now(), 16'h0321);
        check("preload_running", {15'h0, running}, 16'h0001);
        clock1Hz = 1; clock2Hz = 1; clockBlink = 1; pause_btn = 1; clr_btn = 1; sel = 1;
        #2 rst = 1'b0;
        #1;
        check("async_rst_time", time_now(), 16'h0000);
        check("async_rst_running", {15'h0, running}, 16'h0000);
        repeat (2) cyc();
        rst = 1'b1;
        repeat (3) cyc();
        check("release_time", time_now(), 16'h0000);
        check("release_running", {15'h0, running}, 16'h0000);
        check("release_blank", {12'h0, blank}, 16'h0000);
        idle_inputs();
        cyc();
        pulse1();
        check("release_no_count", time_now(), 16'h0000);
        pulse_pause();
        check("release_run", {15'h0, running}, 16'h0001);
        pulse1();
        check("release_0001", time_now(), 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch datapath. Consumes the square-wave time bases from the master clock divider (1 Hz count, 2 Hz adjust, 3 Hz blink) and the debounced user controls. Owns the run/pause/adjust state machine and the MM:SS BCD time value. Drives the seven-segment display multiplexer with four digits plus a per-digit blank mask.

## Interface
Parameters:
- MIN_MAX, 59, terminal value of the minutes field (binary equivalent of BCD max).
- SEC_MAX, 59, terminal value of the seconds field.

Ports:
- clk  in  1  system clock (100 MHz); one clock domain only.
- rst  in  1  asynchronous, active-low reset.
- clock1Hz  in  1  divider 1 Hz square wave, synchronous to clk.
- clock2Hz  in  1  divider 2 Hz square wave, synchronous to clk.
- clockBlink  in  1  divider 3 Hz square wave, synchronous to clk.
- pause_btn  in  1  debounced level; each rising edge toggles run/pause.
- clr_btn  in  1  debounced level; each rising edge clears time to 00:00.
- adj  in  1  level; 1 = adjust mode.
- sel  in  1  adjust field select; 0 = minutes, 1 = seconds.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits.
- blank  out  4  per-digit blank, bit3 = min_tens … bit0 = sec_ones.
- running  out  1  high only in state RUN.

## Operation
- Edge detection: one prev register per input (clock1Hz, clock2Hz, pause_btn, clr_btn). Edge = input sampled 1 at the current clk edge and prev = 0.
- Reset values: time 00:00, state PAUSED, running 0, blank 0000, all prev registers 1. No spurious edge at reset release even if inputs are high.
- States: PAUSED, RUN, ADJUST. Encoding: 2 bits.
- PAUSED → RUN on pause edge (adj=0).
- RUN → PAUSED on pause edge (adj=0).
- Any state → ADJUST while adj=1.
- ADJUST → PAUSED when adj=0, always; the prior run state is not restored.
- RUN counting, on each clock1Hz edge:
  - sec +1; SEC_MAX wraps to 00 with carry into min.
  - min MIN_MAX with carry wraps to 00.
  - So 59:59 → 00:00.
- ADJUST counting, on each clock2Hz edge: the selected field +1, wrapping MAX → 00 with no carry. clock1Hz is ignored. pause edges are ignored.
- Blink: in ADJUST, the two digits of the selected field are blanked while clockBlink = 1. Otherwise blank = 0000.
- Priority within one cycle: clr edge > adj mode change > pause edge > tick.
  - A clr edge zeroes time, discards that cycle's tick, and leaves state unchanged.
  - A tick coinciding with a pause edge uses the state held before that edge: a RUN→PAUSED toggle still applies the tick; a PAUSED→RUN toggle does not.
- Digits always hold valid BCD (tens 0–5, ones 0–9). Increment is BCD: ones 9 → 0 and tens +1.

## Timing
- All outputs are registered. Time, state and blank update at the clk edge that detects the triggering edge; no additional pipeline latency.
- blank follows clockBlink and sel with 1 clk of latency (registered).
- Async reset assertion clears all outputs immediately. Deassertion is taken synchronously by the system reset synchronizer upstream.
- Reset mid-count discards the partial second. The first increment after release is the next clock1Hz edge once in RUN.

## Structure
- Shared package stopwatch_pkg: state encodings (ST_PAUSED, ST_RUN, ST_ADJUST), BCD digit width, default MIN_MAX/SEC_MAX.
- Sub-module bcd60_counter, instantiated twice (minutes, seconds). Ports: inc, clear, tens/ones outputs, carry_out (asserted when inc at MAX). Uses the same clk/rst.
- FSM, edge detectors and blank logic live in stopwatch_ctrl.

## Test plan
- Reset, pause edge, 60 clock1Hz edges → time 00:00→01:00; running=1; each step is +1 s.
- Preload 59:58 via ADJUST, pause edge, 2 clock1Hz edges → 59:59 then 00:00.
- RUN at 00:05, pause edge → running=0; 3 clock1Hz edges leave 00:05; pause edge → resumes; next edge gives 00:06.
- adj=1, sel=1, 62 clock2Hz edges from 00:00 → 00:02 (min unchanged, no carry). With clockBlink=1: blank=0011; sel=0: blank=1100; adj=0 → state PAUSED, blank=0000.
- clr edge in the same cycle as a clock1Hz edge at 12:34 in RUN → 00:00, state RUN. Next tick gives 00:01.
- Reset asserted mid-run at 03:21 with all inputs held high → 00:00, PAUSED. After release, no count until a new pause edge and clock1Hz edge.
